// File: rtl/write_driver_pkg.sv
`default_nettype none
// ============================================================================
// Package     : sram_pkg
// Description : Shared SRAM analog levels and the write-sequencer state type.
// Revision    : 1.0 - initial release
// ============================================================================
package sram_pkg;

  // Rail levels, also used by the column sense amplifiers
  localparam real VDD = 1.5;
  localparam real VSS = 0.0;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRECHARGE = 2'd1,
    DRIVE     = 2'd2,
    RECOVER   = 2'd3
  } wr_state_t;

endpackage
`default_nettype wire

// File: rtl/write_driver_if.sv
`default_nettype none
// ============================================================================
// Interface   : write_driver_if
// Description : Digital write-port handshake (request, data, mask, ready, done).
// Revision    : 1.0 - initial release
// ============================================================================
interface write_driver_if #(
  parameter int COLS = 16
);
  logic            wr_req;
  logic            wr_ready;
  logic [COLS-1:0] wr_data;
  logic [COLS-1:0] wr_mask;
  logic            wr_done;

  modport master (output wr_req, output wr_data, output wr_mask,
                  input  wr_ready, input wr_done);
  modport slave  (input  wr_req, input wr_data, input wr_mask,
                  output wr_ready, output wr_done);
endinterface
`default_nettype wire

// File: rtl/write_driver_col_drv.sv
`default_nettype none
// ============================================================================
// Module      : wr_col_drv
// Description : Single bitline-pair level selector. Drives a differential
//               full-rail pair when enabled, otherwise holds both at VDD.
// Revision    : 1.0 - initial release
// ============================================================================
module wr_col_drv
  import sram_pkg::*;
(
  input  logic pre_en,
  input  logic drv_en,
  input  logic data,
  output real  bl,
  output real  blb
);

  // Precharge wins over drive so BL/BLB can never both sit at VSS
  always_comb begin
    bl  = VDD;
    blb = VDD;
    if (drv_en && !pre_en) begin
      bl  = data ? VDD : VSS;
      blb = data ? VSS : VDD;
    end
  end

endmodule
`default_nettype wire

// File: rtl/write_driver.sv
`default_nettype none
// ============================================================================
// Module      : write_driver
// Description : Sequences one write per request onto the array bitlines:
//               precharge, differential drive, recover, then a done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module write_driver
  import sram_pkg::*;
#(
  parameter int COLS       = 16,
  parameter int PRE_CYCLES = 2,
  parameter int DRV_CYCLES = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  write_driver_if.slave   wr,
  output logic            pre_en,
  output logic [COLS-1:0] drv_en,
  output real             bl_drv  [0:COLS-1],
  output real             blb_drv [0:COLS-1]
);

  localparam int MAX_CYC = (PRE_CYCLES > DRV_CYCLES) ? PRE_CYCLES : DRV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  typedef logic [CNT_W-1:0] cnt_t;
  localparam cnt_t PRE_LAST = cnt_t'(PRE_CYCLES - 1);
  localparam cnt_t DRV_LAST = cnt_t'(DRV_CYCLES - 1);

  generate
    if (PRE_CYCLES < 1) begin : g_bad_pre
      $error("write_driver: PRE_CYCLES must be >= 1");
    end
    if (DRV_CYCLES < 1) begin : g_bad_drv
      $error("write_driver: DRV_CYCLES must be >= 1");
    end
  endgenerate

  wr_state_t       state, state_nxt;
  cnt_t            cnt, cnt_nxt;
  logic [COLS-1:0] data_q, mask_q;
  logic            ready_q, done_q;
  logic            accept;
  logic            pre_nxt, ready_nxt, done_nxt;
  logic [COLS-1:0] drv_nxt;
  real             bl_nxt  [0:COLS-1];
  real             blb_nxt [0:COLS-1];

  assign accept      = wr.wr_req && ready_q;
  assign wr.wr_ready = ready_q;
  assign wr.wr_done  = done_q;

  // State, phase counter and request capture registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      data_q <= '0;
      mask_q <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        data_q <= wr.wr_data;
        mask_q <= wr.wr_mask;
      end
    end
  end

  // Next state, counter and the next-cycle output values (outputs are registered)
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (accept)          state_nxt = PRECHARGE;
      PRECHARGE: if (cnt == PRE_LAST) state_nxt = DRIVE;
      DRIVE:     if (cnt == DRV_LAST) state_nxt = RECOVER;
      RECOVER:                        state_nxt = IDLE;
      default:                        state_nxt = IDLE;
    endcase

    // Counter restarts from zero on every state entry and idles at zero
    if (state_nxt != state || state == IDLE) begin
      cnt_nxt = '0;
    end else begin
      cnt_nxt = cnt + cnt_t'(1);
    end

    pre_nxt   = (state_nxt == PRECHARGE) || (state_nxt == RECOVER);
    drv_nxt   = (state_nxt == DRIVE) ? mask_q : '0;
    ready_nxt = (state_nxt == IDLE);
    done_nxt  = (state_nxt == RECOVER);
  end

  generate
    for (genvar i = 0; i < COLS; i++) begin : g_col
      wr_col_drv u_col (
        .pre_en (pre_nxt),
        .drv_en (drv_nxt[i]),
        .data   (data_q[i]),
        .bl     (bl_nxt[i]),
        .blb    (blb_nxt[i])
      );
    end
  endgenerate

  // Output registers; reset parks everything precharged and ready
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      pre_en  <= 1'b0;
      drv_en  <= '0;
      for (int i = 0; i < COLS; i++) begin
        bl_drv[i]  <= VDD;
        blb_drv[i] <= VDD;
      end
    end else begin
      ready_q <= ready_nxt;
      done_q  <= done_nxt;
      pre_en  <= pre_nxt;
      drv_en  <= drv_nxt;
      for (int i = 0; i < COLS; i++) begin
        bl_drv[i]  <= bl_nxt[i];
        blb_drv[i] <= blb_nxt[i];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_write_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_write_driver
// Description : Directed self-checking bench for write_driver with a queue of
//               expected writes consumed as each sequence plays out.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_write_driver;
  import sram_pkg::*;

  localparam int COLS = 16;

  typedef struct {
    logic [COLS-1:0] data;
    logic [COLS-1:0] mask;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            pre_en;
  logic [COLS-1:0] drv_en;
  real             bl_drv  [0:COLS-1];
  real             blb_drv [0:COLS-1];

  int   compared   = 0;
  int   mismatched = 0;
  exp_t sb[$];

  write_driver_if #(.COLS(COLS)) wif ();

  write_driver #(
    .COLS       (COLS),
    .PRE_CYCLES (2),
    .DRV_CYCLES (3)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr      (wif),
    .pre_en  (pre_en),
    .drv_en  (drv_en),
    .bl_drv  (bl_drv),
    .blb_drv (blb_drv)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Map a rail voltage to a bit; anything off-rail becomes X and never matches
  function automatic logic lvl(input real v);
    if (v == VDD) return 1'b1;
    if (v == VSS) return 1'b0;
    return 1'bx;
  endfunction

  task automatic chk_ctl(input string tag, input logic ready, input logic done,
                         input logic pre, input logic [COLS-1:0] drv);
    chk({tag, ".ready"}, 32'(wif.wr_ready), 32'(ready));
    chk({tag, ".done"},  32'(wif.wr_done),  32'(done));
    chk({tag, ".pre"},   32'(pre_en),       32'(pre));
    chk({tag, ".drv"},   32'(drv_en),       32'(drv));
  endtask

  task automatic chk_lines(input string tag, input logic [COLS-1:0] ebl, input logic [COLS-1:0] eblb);
    logic [COLS-1:0] obl, oblb;
    for (int i = 0; i < COLS; i++) begin
      obl[i]  = lvl(bl_drv[i]);
      oblb[i] = lvl(blb_drv[i]);
    end
    chk({tag, ".bl"},  32'(obl),  32'(ebl));
    chk({tag, ".blb"}, 32'(oblb), 32'(eblb));
  endtask

  // One full write: accept edge, then cycles T+1..T+7 checked against the model.
  // abort_at != 0 pulls rst_n low in that cycle and ends the write there.
  task automatic run_write(input logic [COLS-1:0] d, input logic [COLS-1:0] m,
                           input bit hold, input int abort_at);
    exp_t e;
    wif.wr_req  = 1'b1;
    wif.wr_data = d;
    wif.wr_mask = m;
    sb.push_back('{data: d, mask: m});
    step();
    e = sb.pop_front();
    if (!hold) begin
      wif.wr_req  = 1'b0;
      wif.wr_data = 16'($urandom());
      wif.wr_mask = 16'($urandom());
    end
    for (int k = 1; k <= 7; k++) begin
      if (k == abort_at) begin
        rst_n = 1'b0;
        #1;
        chk_ctl("abort", 1'b1, 1'b0, 1'b0, '0);
        chk_lines("abort", '1, '1);
        for (int j = 0; j < 3; j++) begin
          step();
          chk("abort.no_done", 32'(wif.wr_done), 32'd0);
        end
        rst_n = 1'b1;
        return;
      end
      if (hold && k == 2) wif.wr_data = 16'hFFFF;
      if (k <= 2) begin
        chk_ctl("pre", 1'b0, 1'b0, 1'b1, '0);
        chk_lines("pre", '1, '1);
      end else if (k <= 5) begin
        chk_ctl("drive", 1'b0, 1'b0, 1'b0, e.mask);
        chk_lines("drive", ~e.mask | e.data, ~e.mask | ~e.data);
      end else if (k == 6) begin
        chk_ctl("recover", 1'b0, 1'b1, 1'b1, '0);
        chk_lines("recover", '1, '1);
      end else begin
        chk_ctl("idle", 1'b1, 1'b0, 1'b0, '0);
        chk_lines("idle", '1, '1);
      end
      if (k < 7) step();
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    wif.wr_req  = 1'b0;
    wif.wr_data = '0;
    wif.wr_mask = '0;
    step();
    step();
    chk_ctl("reset", 1'b1, 1'b0, 1'b0, '0);
    chk_lines("reset", '1, '1);
    rst_n = 1'b1;
    step();
    chk_ctl("post_reset", 1'b1, 1'b0, 1'b0, '0);

    // Basic full-mask write
    run_write(16'hA5C3, 16'hFFFF, 1'b0, 0);
    step();

    // Partial mask writing zeros into columns 4..7
    run_write(16'h0000, 16'h00F0, 1'b0, 0);
    step();

    // Held request: data changes mid-write, second request taken on first idle cycle
    run_write(16'h1234, 16'hFFFF, 1'b1, 0);
    run_write(16'hFFFF, 16'hFFFF, 1'b0, 0);
    step();

    // All-zero mask still runs the full sequence
    run_write(16'hA5A5, 16'h0000, 1'b0, 0);
    step();

    // Reset during the second DRIVE cycle, then a normal write
    run_write(16'hC3C3, 16'hFFFF, 1'b0, 4);
    step();
    chk_ctl("after_abort", 1'b1, 1'b0, 1'b0, '0);
    run_write(16'h5A5A, 16'h0FF0, 1'b0, 0);

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
